// File: rtl/hash_host_drv_if.sv
// Pin-level bundle between the host driver, its local message source and the hash core.
// master = host driver side; slave = the source/core side of the same wires.
interface hash_host_drv_if;
  logic       msg_valid_i;
  logic [7:0] msg_data_i;
  logic       msg_last_i;
  logic       msg_ready_o;
  logic [7:0] dut_data_o;
  logic       dut_valid_o;
  logic [1:0] dut_cmd_o;
  logic       dut_ready_i;
  logic       dut_hash_valid_i;
  logic [7:0] dut_hash_i;

  modport master (
    input  msg_valid_i, msg_data_i, msg_last_i, dut_ready_i, dut_hash_valid_i, dut_hash_i,
    output msg_ready_o, dut_data_o, dut_valid_o, dut_cmd_o
  );

  modport slave (
    output msg_valid_i, msg_data_i, msg_last_i, dut_ready_i, dut_hash_valid_i, dut_hash_i,
    input  msg_ready_o, dut_data_o, dut_valid_o, dut_cmd_o
  );
endinterface

// File: rtl/hash_host_drv.sv
// Host driver for the hash core: sends {kk,nn} config then message bytes (1 byte/clk, held while core stalls),
// captures nn digest bytes into a 1-cycle-latency readback buffer. HASH_HOST_DRV_TIMEOUT_EN adds a WAIT_HASH watchdog.
module hash_host_drv #(
  parameter int MAX_NN         = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [6:0]       kk_i,
  input  logic [6:0]       nn_i,
  input  logic [5:0]       rd_addr_i,
  output logic [7:0]       rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  hash_host_drv_if.master  bus
);

  localparam int         AW     = $clog2(MAX_NN);
  localparam logic [6:0] NN_MAX = 7'(MAX_NN);

  if (MAX_NN < 2 || MAX_NN > 64 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("hash_host_drv: unsupported parameter values");
  end

  typedef enum logic [2:0] {IDLE, CFG0, CFG1, MSG, WAIT_HASH, DONE, ERR} state_e;

  state_e     state_q;
  logic [6:0] nn_q;
  logic [6:0] cap_cnt_q;
  logic [7:0] dut_data_q;
  logic       dut_valid_q;
  logic [1:0] dut_cmd_q;
  logic       last_sent_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] rd_data_q;
  logic [7:0] dig_mem [MAX_NN];

`ifdef HASH_HOST_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tout_q;
`endif

  logic xfer;
  logic msg_rdy;
  logic msg_acc;
  logic cap_we;

  // The output register frees up on the cycle the nn config byte leaves, so the first
  // message byte can already be taken in CFG1 and the stream stays gapless.
  assign xfer    = dut_valid_q && bus.dut_ready_i;
  assign msg_rdy = ((state_q == MSG) || (state_q == CFG1)) &&
                   (!dut_valid_q || bus.dut_ready_i) && !last_sent_q;
  assign msg_acc = bus.msg_valid_i && msg_rdy;
  assign cap_we  = (state_q == WAIT_HASH) && bus.dut_hash_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nn_q        <= '0;
      cap_cnt_q   <= '0;
      dut_data_q  <= '0;
      dut_valid_q <= 1'b0;
      dut_cmd_q   <= 2'b00;
      last_sent_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef HASH_HOST_DRV_TIMEOUT_EN
      tout_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          dut_valid_q <= 1'b0;
          if (start_i) begin
            nn_q        <= nn_i;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cap_cnt_q   <= '0;
            last_sent_q <= 1'b0;
            if (nn_i == 7'd0 || nn_i > NN_MAX) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q     <= CFG0;
              dut_valid_q <= 1'b1;
              dut_cmd_q   <= 2'b01;
              dut_data_q  <= {1'b0, kk_i};
            end
          end else if (bus.dut_hash_valid_i) begin
            err_q <= 1'b1;
          end
        end
        CFG0: begin
          if (bus.dut_hash_valid_i) begin
            state_q     <= ERR;
            err_q       <= 1'b1;
            dut_valid_q <= 1'b0;
          end else if (xfer) begin
            state_q    <= CFG1;
            dut_cmd_q  <= 2'b01;
            dut_data_q <= {1'b0, nn_q};
          end
        end
        CFG1: begin
          if (bus.dut_hash_valid_i) begin
            state_q     <= ERR;
            err_q       <= 1'b1;
            dut_valid_q <= 1'b0;
          end else if (xfer) begin
            state_q <= MSG;
            if (msg_acc) begin
              dut_data_q  <= bus.msg_data_i;
              dut_cmd_q   <= bus.msg_last_i ? 2'b11 : 2'b10;
              last_sent_q <= bus.msg_last_i;
            end else begin
              dut_valid_q <= 1'b0;
            end
          end
        end
        MSG: begin
          if (bus.dut_hash_valid_i) begin
            state_q     <= ERR;
            err_q       <= 1'b1;
            dut_valid_q <= 1'b0;
          end else if (msg_acc) begin
            dut_valid_q <= 1'b1;
            dut_data_q  <= bus.msg_data_i;
            dut_cmd_q   <= bus.msg_last_i ? 2'b11 : 2'b10;
            last_sent_q <= bus.msg_last_i;
          end else if (xfer) begin
            dut_valid_q <= 1'b0;
            if (last_sent_q) begin
              state_q <= WAIT_HASH;
`ifdef HASH_HOST_DRV_TIMEOUT_EN
              tout_q  <= '0;
`endif
            end
          end
        end
        WAIT_HASH: begin
          if (cap_we) begin
            cap_cnt_q <= cap_cnt_q + 7'd1;
            if (cap_cnt_q + 7'd1 == nn_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
`ifdef HASH_HOST_DRV_TIMEOUT_EN
          if (cap_we) begin
            tout_q <= '0;
          end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            tout_q <= tout_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer is deliberately not reset; a same-cycle read of the written slot sees the old byte.
  always_ff @(posedge clk) begin
    if (!rst && cap_we) dig_mem[cap_cnt_q[AW-1:0]] <= bus.dut_hash_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= dig_mem[rd_addr_i];
  end

  assign bus.msg_ready_o = msg_rdy;
  assign bus.dut_data_o  = dut_data_q;
  assign bus.dut_valid_o = dut_valid_q;
  assign bus.dut_cmd_o   = dut_cmd_q;
  assign rd_data_o       = rd_data_q;
  assign busy_o          = !(state_q inside {IDLE, DONE, ERR});
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_hash_host_drv.sv
// Directed + randomized bench for hash_host_drv: expected pin traffic is built from kk/nn/message,
// digest readback is checked against a byte-array model of the buffer.
module tb_hash_host_drv;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [6:0] kk_i = '0;
  logic [6:0] nn_i = '0;
  logic [5:0] rd_addr_i = '0;
  logic [7:0] rd_data_o;
  logic       busy_o, done_o, err_o;

  hash_host_drv_if bus ();

  hash_host_drv #(.MAX_NN(64), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [9:0] obs_q[$];
  int         obs_t[$];
  logic [9:0] exp_q[$];
  logic [7:0] msg_q[$];
  int         idx = 0;
  logic [7:0] mem_model [64];
  bit         mem_known [64];
  bit         chk_stable = 1'b0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_word = '0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // Core-side monitor: logs every transfer and checks the word holds while stalled.
  always @(posedge clk) begin
    if (chk_stable && prev_stall) begin
      total++;
      assert (bus.dut_valid_o === 1'b1 && {bus.dut_cmd_o, bus.dut_data_o} === prev_word) else begin
        bad++;
        $error("FAIL stall_hold observed=0x%0h expected=0x%0h", {bus.dut_cmd_o, bus.dut_data_o}, prev_word);
      end
    end
    if (!rst && bus.dut_valid_o && bus.dut_ready_i) begin
      obs_q.push_back({bus.dut_cmd_o, bus.dut_data_o});
      obs_t.push_back(cyc);
    end
    prev_stall <= !rst && bus.dut_valid_o && !bus.dut_ready_i;
    prev_word  <= {bus.dut_cmd_o, bus.dut_data_o};
    cyc        <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] kk, input logic [6:0] nn);
    obs_q.delete();
    obs_t.delete();
    start_i = 1'b1;
    kk_i    = kk;
    nn_i    = nn;
    tick();
    start_i = 1'b0;
  endtask

  task automatic load_msg(input int n, input bit abc);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
    idx = 0;
  endtask

  task automatic feed(input int upto, input bit rnd_rdy, input bit wait_all);
    int guard = 0;
    while ((idx < upto || (wait_all && obs_q.size() < exp_q.size())) && guard < 3000) begin
      bus.dut_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.msg_valid_i = (idx < msg_q.size());
      bus.msg_data_i  = (idx < msg_q.size()) ? msg_q[idx] : 8'h00;
      bus.msg_last_i  = (idx == msg_q.size() - 1);
      #1;
      if (bus.msg_valid_i && bus.msg_ready_o) idx++;
      tick();
      guard++;
    end
    bus.msg_valid_i = 1'b0;
    bus.msg_last_i  = 1'b0;
  endtask

  task automatic return_hash(input int nn, input bit seq);
    int         h = 0;
    int         guard = 0;
    logic [7:0] hd;
    logic [7:0] old;
    bit         known;
    while (h < nn && guard < 1000) begin
      if (seq || $urandom_range(0, 2) != 0) begin
        hd = seq ? 8'(h) : 8'($urandom);
        bus.dut_hash_valid_i = 1'b1;
        bus.dut_hash_i       = hd;
        rd_addr_i            = 6'(h);
        old   = mem_model[h];
        known = mem_known[h];
        if (h == nn - 1) chk("done_early", done_o, 0);
        tick();
        if (known) chk("rd_during_wr", rd_data_o, old);
        mem_model[h] = hd;
        mem_known[h] = 1'b1;
        h++;
      end else begin
        bus.dut_hash_valid_i = 1'b0;
        tick();
      end
      guard++;
    end
    bus.dut_hash_valid_i = 1'b0;
  endtask

  task automatic run_txn(input logic [6:0] kk, input logic [6:0] nn, input int n,
                         input bit rnd_rdy, input bit seq, input bit abc);
    int n11 = 0;
    load_msg(n, abc);
    exp_q.delete();
    exp_q.push_back({2'b01, 1'b0, kk});
    exp_q.push_back({2'b01, 1'b0, nn});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1) ? 2'b11 : 2'b10, msg_q[i]});
    do_start(kk, nn);
    chk("busy_after_start", busy_o, 1);
    chk_stable = rnd_rdy;
    feed(n, rnd_rdy, 1'b1);
    chk_stable = 1'b0;
    chk("xfer_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk("xfer_word", obs_q[i], exp_q[i]);
      if (obs_q[i][9:8] == 2'b11) n11++;
    end
    chk("last_once", n11, 1);
    chk("msg_ready_wait", bus.msg_ready_o, 0);
    return_hash(nn, seq);
    chk("done", done_o, 1);
    chk("busy_done", busy_o, 0);
    chk("err_done", err_o, 0);
    for (int a = 0; a < nn; a++) begin
      rd_addr_i = 6'(a);
      tick();
      chk("readback", rd_data_o, mem_model[a]);
    end
  endtask

  initial begin
    bus.msg_valid_i      = 1'b0;
    bus.msg_data_i       = '0;
    bus.msg_last_i       = 1'b0;
    bus.dut_ready_i      = 1'b0;
    bus.dut_hash_valid_i = 1'b0;
    bus.dut_hash_i       = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.dut_valid_o, 0);
    chk("rst_cmd", bus.dut_cmd_o, 0);
    chk("rst_data", bus.dut_data_o, 0);
    chk("rst_ready", bus.msg_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd", rd_data_o, 0);
    rst = 1'b0;
    tick();

    // "abc", kk=0 nn=32, core always ready, digest 0x00..0x1F
    run_txn(7'd0, 7'd32, 3, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < obs_t.size(); i++) chk("abc_consecutive", obs_t[i] - obs_t[0], i);
    rd_addr_i = 6'd5;
    tick();
    chk("rd_addr5", rd_data_o, 8'h05);

    // 100-byte message with random core stalls and gappy digest
    run_txn(7'($urandom), 7'($urandom_range(1, 64)), 100, 1'b1, 1'b0, 1'b0);

    // illegal nn values, then recovery
    do_start(7'd3, 7'd0);
    chk("nn0_err", err_o, 1);
    chk("nn0_busy", busy_o, 0);
    repeat (4) tick();
    chk("nn0_traffic", obs_q.size(), 0);
    do_start(7'd3, 7'd65);
    chk("nn65_err", err_o, 1);
    repeat (4) tick();
    chk("nn65_traffic", obs_q.size(), 0);
    chk("nn65_valid", bus.dut_valid_o, 0);
    run_txn(7'h05, 7'd1, 4, 1'b1, 1'b0, 1'b0);

    // digest strobe while message is streaming
    load_msg(5, 1'b0);
    do_start(7'd1, 7'd8);
    feed(2, 1'b0, 1'b0);
    bus.dut_ready_i      = 1'b0;
    bus.dut_hash_valid_i = 1'b1;
    tick();
    bus.dut_hash_valid_i = 1'b0;
    chk("msg_hv_err", err_o, 1);
    chk("msg_hv_valid", bus.dut_valid_o, 0);
    chk("msg_hv_busy", busy_o, 0);
    chk("msg_hv_ready", bus.msg_ready_o, 0);

    // reset mid-message
    load_msg(3, 1'b0);
    do_start(7'd2, 7'd16);
    feed(2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", bus.dut_valid_o, 0);
    chk("mid_rst_cmd", bus.dut_cmd_o, 0);
    chk("mid_rst_data", bus.dut_data_o, 0);
    chk("mid_rst_ready", bus.msg_ready_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_rd", rd_data_o, 0);
    run_txn(7'($urandom), 7'($urandom_range(1, 64)), 20, 1'b1, 1'b0, 1'b0);

    // digest strobe after completion: sticky error, state stays DONE
    bus.dut_hash_valid_i = 1'b1;
    tick();
    bus.dut_hash_valid_i = 1'b0;
    chk("done_hv_err", err_o, 1);
    chk("done_hv_done", done_o, 1);
    chk("done_hv_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
